// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - up/down counter bus monitor: direction decode, lock tracking, sequence error count
module count_monitor #(
  parameter int unsigned LOCK_N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       valid_in,
  input  logic       clr_err,
  output logic [1:0] dir_out,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0] LOCK_VAL = 4'(LOCK_N);
  localparam logic [1:0] DIR_UNKNOWN = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b01;
  localparam logic [1:0] DIR_DOWN    = 2'b10;
  localparam logic [1:0] DIR_HOLD    = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       have_prev_q, have_prev_d;
  logic [3:0] run_q, run_d;
  logic       run_dir_q, run_dir_d;
  logic [1:0] dir_out_q, dir_out_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;

  logic [3:0] delta;
  logic       is_up, is_down, is_hold, is_step, step_dir;

  // Classify the incoming sample against the previous one (mod-16, so wrap is a unit step)
  always_comb begin
    delta    = count_in - prev_q;
    is_up    = (delta == 4'd1);
    is_down  = (delta == 4'd15);
    is_hold  = (delta == 4'd0);
    is_step  = is_up | is_down;
    step_dir = is_down;
  end

  // Next-state logic for the lock FSM, run tracking and error counter
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    run_dir_d   = run_dir_q;
    dir_out_d   = dir_out_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (valid_in) begin
      prev_d = count_in;
      if (!have_prev_q) begin
        // First sample only seeds the history
        have_prev_d = 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            if (is_step) begin
              if ((step_dir == run_dir_q) && (run_q != 4'd0)) begin
                run_d = run_q + 4'd1;
              end else begin
                run_d     = 4'd1;
                run_dir_d = step_dir;
              end
              if (run_d == LOCK_VAL) begin
                state_d   = LOCKED;
                locked_d  = 1'b1;
                dir_out_d = run_dir_d ? DIR_DOWN : DIR_UP;
              end
            end else if (!is_hold) begin
              // A jump while searching just restarts the run; nothing is reported
              run_d = 4'd0;
            end
          end
          LOCKED: begin
            if (is_up) begin
              dir_out_d = DIR_UP;
            end else if (is_down) begin
              dir_out_d = DIR_DOWN;
            end else if (is_hold) begin
              dir_out_d = DIR_HOLD;
            end else begin
              err_pulse_d = 1'b1;
              if (err_count_q != 8'hff) begin
                err_count_d = err_count_q + 8'd1;
              end
              state_d   = SEARCH;
              locked_d  = 1'b0;
              dir_out_d = DIR_UNKNOWN;
              run_d     = 4'd0;
            end
          end
          default: begin
            state_d = SEARCH;
          end
        endcase
      end
    end

    // Clearing wins over history but still records an error arriving on the same edge
    if (clr_err) begin
      err_count_d = err_pulse_d ? 8'd1 : 8'd0;
    end
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
      run_q       <= 4'd0;
      run_dir_q   <= 1'b0;
      dir_out_q   <= DIR_UNKNOWN;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      run_dir_q   <= run_dir_d;
      dir_out_q   <= dir_out_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign dir_out   = dir_out_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed table-driven bench for count_monitor
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       valid_in;
  logic       clr_err;
  logic [1:0] dir_out;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [1:0] dir_out1;
  logic       locked1;
  logic       err_pulse1;
  logic [7:0] err_count1;

  int checks;
  int errors;

  count_monitor #(.LOCK_N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .valid_in  (valid_in),
    .clr_err   (clr_err),
    .dir_out   (dir_out),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  count_monitor #(.LOCK_N(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .valid_in  (valid_in),
    .clr_err   (clr_err),
    .dir_out   (dir_out1),
    .locked    (locked1),
    .err_pulse (err_pulse1),
    .err_count (err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       clr;
    logic [1:0] dir;
    logic       lk;
    logic       p;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v, logic [3:0] c, logic clr,
                              logic [1:0] dir, logic lk, logic p, logic [7:0] ec);
    vec_t t;
    t.v = v; t.c = c; t.clr = clr; t.dir = dir; t.lk = lk; t.p = p; t.ec = ec;
    vecs.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(logic v, logic [3:0] c, logic clr);
    @(negedge clk);
    valid_in = v;
    count_in = c;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string nm, logic [1:0] d, logic lk, logic p, logic [7:0] ec);
    chk({nm, " dir"}, 32'(dir_out), 32'(d));
    chk({nm, " locked"}, 32'(locked), 32'(lk));
    chk({nm, " pulse"}, 32'(err_pulse), 32'(p));
    chk({nm, " errcnt"}, 32'(err_count), 32'(ec));
  endtask

  logic [3:0] p;
  int         model_ec;

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    count_in = 4'd0;
    clr_err  = 1'b0;

    // up lock, freeze, hold/reversal, down lock with wrap, errors, clear, search corners
    add(1, 5, 0, 2'b00, 0, 0, 0);
    add(1, 6, 0, 2'b00, 0, 0, 0);
    add(1, 7, 0, 2'b00, 0, 0, 0);
    add(1, 8, 0, 2'b01, 1, 0, 0);
    add(1, 9, 0, 2'b01, 1, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 3, 0, 2'b01, 1, 0, 0);
    add(1, 10, 0, 2'b01, 1, 0, 0);
    add(1, 10, 0, 2'b11, 1, 0, 0);
    add(1, 9, 0, 2'b10, 1, 0, 0);
    add(1, 3, 0, 2'b00, 0, 1, 1);
    add(1, 2, 0, 2'b00, 0, 0, 1);
    add(1, 1, 0, 2'b00, 0, 0, 1);
    add(1, 0, 0, 2'b10, 1, 0, 1);
    add(1, 15, 0, 2'b10, 1, 0, 1);
    add(1, 14, 0, 2'b10, 1, 0, 1);
    add(1, 3, 0, 2'b00, 0, 1, 2);
    add(0, 0, 0, 2'b00, 0, 0, 2);
    add(1, 4, 0, 2'b00, 0, 0, 2);
    add(1, 5, 0, 2'b00, 0, 0, 2);
    add(1, 6, 0, 2'b01, 1, 0, 2);
    add(1, 6, 0, 2'b11, 1, 0, 2);
    add(1, 6, 0, 2'b11, 1, 0, 2);
    add(1, 5, 0, 2'b10, 1, 0, 2);
    add(1, 5, 1, 2'b11, 1, 0, 0);
    add(1, 12, 0, 2'b00, 0, 1, 1);
    add(1, 13, 0, 2'b00, 0, 0, 1);
    add(1, 14, 0, 2'b00, 0, 0, 1);
    add(1, 14, 0, 2'b00, 0, 0, 1);
    add(1, 15, 0, 2'b01, 1, 0, 1);
    add(1, 7, 0, 2'b00, 0, 1, 2);
    add(1, 8, 0, 2'b00, 0, 0, 2);
    add(1, 9, 0, 2'b00, 0, 0, 2);
    add(1, 3, 0, 2'b00, 0, 0, 2);
    add(1, 4, 0, 2'b00, 0, 0, 2);
    add(1, 5, 0, 2'b00, 0, 0, 2);
    add(1, 6, 0, 2'b01, 1, 0, 2);
    add(1, 0, 0, 2'b00, 0, 1, 3);
    add(1, 1, 0, 2'b00, 0, 0, 3);
    add(1, 0, 0, 2'b00, 0, 0, 3);
    add(1, 15, 0, 2'b00, 0, 0, 3);
    add(1, 14, 0, 2'b10, 1, 0, 3);

    #2;
    chk_out("reset", 2'b00, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].clr);
      chk_out($sformatf("vec%0d", i), vecs[i].dir, vecs[i].lk, vecs[i].p, vecs[i].ec);
      if (i < 2) begin
        chk($sformatf("vec%0d lock1 locked", i), 32'(locked1), 32'(i == 1));
        chk($sformatf("vec%0d lock1 dir", i), 32'(dir_out1), (i == 1) ? 32'd1 : 32'd0);
      end
    end

    // Repeated jump + relock to drive the counter into saturation
    p        = 4'd14;
    model_ec = 3;
    for (int k = 0; k < 260; k++) begin
      p = p + 4'd8;
      step(1, p, 0);
      model_ec = (model_ec < 255) ? model_ec + 1 : 255;
      chk($sformatf("sat%0d pulse", k), 32'(err_pulse), 32'd1);
      chk($sformatf("sat%0d errcnt", k), 32'(err_count), 32'(model_ec));
      for (int s = 0; s < 3; s++) begin
        p = p + 4'd1;
        step(1, p, 0);
      end
      if (k == 259) chk("sat relock", 32'(locked), 32'd1);
    end

    p = p + 4'd8;
    step(1, p, 1);
    chk_out("clr+jump", 2'b00, 0, 1, 1);
    step(0, p, 0);
    chk_out("after clr", 2'b00, 0, 0, 1);

    for (int s = 0; s < 3; s++) begin
      p = p + 4'd1;
      step(1, p, 0);
    end
    chk_out("prereset lock", 2'b01, 1, 0, 1);

    // Asynchronous reset mid-cycle while locked
    #3;
    reset = 1'b0;
    #1;
    chk_out("async reset", 2'b00, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 2, 0);
    chk_out("rst s2", 2'b00, 0, 0, 0);
    step(1, 3, 0);
    chk_out("rst s3", 2'b00, 0, 0, 0);
    step(1, 4, 0);
    chk_out("rst s4", 2'b00, 0, 0, 0);
    step(1, 5, 0);
    chk_out("rst s5", 2'b01, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
